// File: rtl/dmac_cfg_arbiter_pkg.sv
// Shared state encoding and sizing helpers for the DMAC_CFG access arbiter.
package dmac_cfg_pkg;

    localparam int CFG_DATA_W  = 32;
    localparam int CFG_NUM_REQ = 4;
    localparam int CFG_IDX_W   = $clog2(CFG_NUM_REQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    // Index width that stays legal for any requester count.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmac_cfg_arbiter_if.sv
// Requester handshake plus DMAC_CFG port bundle; slave side is the arbiter.
interface dmac_cfg_arbiter_if
    import dmac_cfg_pkg::*;
#(
    parameter int NUM_REQ = CFG_NUM_REQ,
    parameter int DATA_W  = CFG_DATA_W
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      cfg_wren;
    logic                      cfg_rden;
    logic [DATA_W-1:0]         cfg_wdata;
    logic [DATA_W-1:0]         cfg_rdata;

    modport slave (
        input  req_valid, req_write, req_wdata, cfg_rdata,
        output req_ready, rsp_valid, rsp_rdata, cfg_wren, cfg_rden, cfg_wdata
    );

    modport master (
        output req_valid, req_write, req_wdata, cfg_rdata,
        input  req_ready, rsp_valid, rsp_rdata, cfg_wren, cfg_rden, cfg_wdata
    );

endinterface

// File: rtl/dmac_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module dmac_rr_arbiter
    import dmac_cfg_pkg::*;
#(
    parameter int NUM_REQ = CFG_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!any_grant && req[cand]) begin
                any_grant   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmac_cfg_arbiter.sv
// Round-robin sequencer sharing the single-port DMAC_CFG register between
// NUM_REQ requesters; every output is driven straight from a flop.
module dmac_cfg_arbiter
    import dmac_cfg_pkg::*;
#(
    parameter int NUM_REQ = CFG_NUM_REQ,
    parameter int DATA_W  = CFG_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    dmac_cfg_arbiter_if.slave bus
);

    // state   | meaning
    // IDLE    | arbitrate; winner, direction and wdata latched at the edge
    // ISSUE   | req_ready pulse and exactly one cfg strobe
    // CAPTURE | DMAC_CFG read data registered into rsp_rdata
    // RESP    | rsp_valid pulse to the winner, then back to IDLE

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [NUM_REQ-1:0] grant, grant_nxt;
    logic               is_write, is_write_nxt;

    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               pick_write;

    logic [NUM_REQ-1:0] ready_q, ready_nxt;
    logic [NUM_REQ-1:0] rsp_q, rsp_nxt;
    logic               wren_q, wren_nxt;
    logic               rden_q, rden_nxt;
    logic [DATA_W-1:0]  wdata_q, wdata_nxt;
    logic [DATA_W-1:0]  rdata_q, rdata_nxt;

    dmac_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (pick),
        .grant_idx (pick_idx),
        .any_grant (pick_any)
    );

    assign pick_write = bus.req_write[pick_idx];

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        grant_nxt    = grant;
        is_write_nxt = is_write;
        ready_nxt    = '0;
        rsp_nxt      = '0;
        wren_nxt     = 1'b0;
        rden_nxt     = 1'b0;
        wdata_nxt    = '0;
        rdata_nxt    = rdata_q;

        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt    = ISSUE;
                    grant_nxt    = pick;
                    is_write_nxt = pick_write;
                    ptr_nxt      = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                    ready_nxt    = pick;
                    wren_nxt     = pick_write;
                    rden_nxt     = !pick_write;
                    if (pick_write) begin
                        wdata_nxt = bus.req_wdata[pick_idx*DATA_W +: DATA_W];
                    end
                end
            end
            ISSUE: begin
                if (is_write) begin
                    state_nxt = RESP;
                    rsp_nxt   = grant;
                end else begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                // DMAC_CFG presents rdata the cycle after rden.
                state_nxt = RESP;
                rsp_nxt   = grant;
                rdata_nxt = bus.cfg_rdata;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Reset is asserted high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            grant    <= '0;
            is_write <= 1'b0;
            ready_q  <= '0;
            rsp_q    <= '0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            grant    <= grant_nxt;
            is_write <= is_write_nxt;
            ready_q  <= ready_nxt;
            rsp_q    <= rsp_nxt;
            wren_q   <= wren_nxt;
            rden_q   <= rden_nxt;
            wdata_q  <= wdata_nxt;
            rdata_q  <= rdata_nxt;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_q;
    assign bus.cfg_wren  = wren_q;
    assign bus.cfg_rden  = rden_q;
    assign bus.cfg_wdata = wdata_q;
    assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dmac_cfg_arbiter.sv
// Bench for dmac_cfg_arbiter: transaction-schedule model, vector table, directed corners, random traffic.
module tb_dmac_cfg_arbiter;
    import dmac_cfg_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmac_cfg_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    dmac_cfg_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Stand-in for DMAC_CFG: write on wren, read data one cycle after rden.
    logic [W-1:0] cfg_reg = '0;
    always @(posedge clk) begin
        if (bus.cfg_wren) cfg_reg <= bus.cfg_wdata;
        if (bus.cfg_rden) bus.cfg_rdata <= cfg_reg;
    end

    // Expected outputs for the next few cycles, filled when the model grants.
    typedef struct packed {
        logic [N-1:0] ready;
        logic [N-1:0] rsp;
        logic         wren;
        logic         rden;
        logic [W-1:0] wdata;
        logic         rd_upd;
        logic [W-1:0] rd_val;
    } exp_t;

    exp_t         ew [4];
    int           cyc, free_at, ptr_m;
    logic [W-1:0] cfg_m, rdata_m;
    logic         in_reset, rand_mode;
    logic [N-1:0] rereq;
    int           rq_st [N];
    int           rsp_cnt [N];
    int           grants_q [$];
    int           gcyc_q [$];
    int           checks, errors;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        int w;
        w = -1;
        if (!in_reset && cyc >= free_at && |bus.req_valid) begin
            for (int k = 0; k < N; k++)
                if (w < 0 && bus.req_valid[(ptr_m + k) % N]) w = (ptr_m + k) % N;
            ptr_m = (w + 1) % N;
            ew[0].ready[w] = 1'b1;
            if (bus.req_write[w]) begin
                ew[0].wren  = 1'b1;
                ew[0].wdata = bus.req_wdata[w*W +: W];
                cfg_m       = bus.req_wdata[w*W +: W];
                ew[1].rsp[w] = 1'b1;
                free_at     = cyc + 3;
            end else begin
                ew[0].rden    = 1'b1;
                ew[2].rsp[w]  = 1'b1;
                ew[2].rd_upd  = 1'b1;
                ew[2].rd_val  = cfg_m;
                free_at       = cyc + 4;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (ew[0].rd_upd) rdata_m = ew[0].rd_val;
        chk("req_ready", bus.req_ready, ew[0].ready);
        chk("rsp_valid", bus.rsp_valid, ew[0].rsp);
        chk("cfg_wren",  bus.cfg_wren,  ew[0].wren);
        chk("cfg_rden",  bus.cfg_rden,  ew[0].rden);
        chk("cfg_wdata", bus.cfg_wdata, ew[0].wdata);
        chk("rsp_rdata", bus.rsp_rdata, rdata_m);
        ew[0] = ew[1]; ew[1] = ew[2]; ew[2] = ew[3]; ew[3] = '0;

        for (int i = 0; i < N; i++) begin
            if (bus.req_ready[i]) begin
                grants_q.push_back(i);
                gcyc_q.push_back(cyc);
                bus.req_valid[i] = 1'b0;
                rq_st[i] = 2;
                if (rand_mode) begin
                    bus.req_write[i] = 1'($urandom_range(0, 1));
                    bus.req_wdata[i*W +: W] = $urandom;
                end
            end
            if (bus.rsp_valid[i]) begin
                rsp_cnt[i]++;
                rq_st[i] = 0;
                if (rereq[i]) begin
                    bus.req_valid[i] = 1'b1;
                    rq_st[i] = 1;
                end
            end
            if (rand_mode) begin
                if (rq_st[i] == 0 && $urandom_range(0, 3) == 0) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_write[i] = 1'($urandom_range(0, 1));
                    bus.req_wdata[i*W +: W] = $urandom;
                    rq_st[i] = 1;
                end else if (rq_st[i] == 1 && $urandom_range(0, 31) == 0) begin
                    bus.req_valid[i] = 1'b0;
                    rq_st[i] = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b1;
        in_reset = 1'b1;
        #1;
        chk("rst_ready",  bus.req_ready, '0);
        chk("rst_rsp",    bus.rsp_valid, '0);
        chk("rst_strobe", {bus.cfg_wren, bus.cfg_rden}, '0);
        chk("rst_wdata",  bus.cfg_wdata, '0);
        chk("rst_rdata",  bus.rsp_rdata, '0);
        for (int k = 0; k < 4; k++) ew[k] = '0;
        rdata_m = '0;
        ptr_m   = 0;
        for (int i = 0; i < N; i++) rq_st[i] = 0;
        step();
        step();
        rst_n    = 1'b0;
        in_reset = 1'b0;
        free_at  = cyc;
    endtask

    task automatic request(input int i, input logic wr, input logic [W-1:0] d);
        bus.req_valid[i]        = 1'b1;
        bus.req_write[i]        = wr;
        bus.req_wdata[i*W +: W] = d;
    endtask

    typedef struct {
        int           idx;
        logic         wr;
        logic [W-1:0] wdata;
        logic [N-1:0] e_onehot;
        int           e_lat;
        logic [W-1:0] e_rdata;
    } vec_t;

    vec_t vt [8];
    int   nidle;

    initial begin
        checks = 0; errors = 0; cyc = 0; free_at = 0; ptr_m = 0;
        cfg_m = '0; rdata_m = '0; in_reset = 1'b1; rand_mode = 1'b0; rereq = '0;
        bus.req_valid = '0; bus.req_write = '0; bus.req_wdata = '0;
        for (int k = 0; k < 4; k++) ew[k] = '0;
        for (int i = 0; i < N; i++) begin rq_st[i] = 0; rsp_cnt[i] = 0; end

        vt[0] = '{0, 1'b1, 32'h0123_4567, 4'b0001, 2, 32'h0};
        vt[1] = '{0, 1'b0, 32'h0,         4'b0001, 3, 32'h0123_4567};
        vt[2] = '{3, 1'b1, 32'hDEAD_BEEF, 4'b1000, 2, 32'h0};
        vt[3] = '{2, 1'b0, 32'h0,         4'b0100, 3, 32'hDEAD_BEEF};
        vt[4] = '{1, 1'b1, 32'h0000_0000, 4'b0010, 2, 32'h0};
        vt[5] = '{1, 1'b0, 32'h5555_5555, 4'b0010, 3, 32'h0000_0000};
        vt[6] = '{3, 1'b1, 32'hFFFF_FFFF, 4'b1000, 2, 32'h0};
        vt[7] = '{0, 1'b0, 32'h0,         4'b0001, 3, 32'hFFFF_FFFF};

        @(negedge clk);
        do_reset();

        // Single transactions from the vector table.
        for (int v = 0; v < 8; v++) begin
            request(vt[v].idx, vt[v].wr, vt[v].wdata);
            for (int k = 1; k <= vt[v].e_lat; k++) begin
                step();
                if (k == 1) begin
                    chk("vec_ready", bus.req_ready, vt[v].e_onehot);
                    chk("vec_wren",  bus.cfg_wren, vt[v].wr);
                    chk("vec_rden",  bus.cfg_rden, !vt[v].wr);
                    chk("vec_wdata", bus.cfg_wdata, vt[v].wr ? vt[v].wdata : '0);
                end
                if (k == vt[v].e_lat) begin
                    chk("vec_rsp", bus.rsp_valid, vt[v].e_onehot);
                    if (!vt[v].wr) chk("vec_rdata", bus.rsp_rdata, vt[v].e_rdata);
                end
            end
            step();
        end

        // All four write at once after reset: grants 0,1,2,3 three cycles apart.
        do_reset();
        grants_q.delete(); gcyc_q.delete();
        for (int i = 0; i < N; i++) request(i, 1'b1, 32'hA0 + i);
        repeat (14) step();
        chk("sim_ngrants", grants_q.size(), 4);
        for (int i = 0; i < 4 && i < grants_q.size(); i++) begin
            chk("sim_order", grants_q[i], i);
            if (i > 0) chk("sim_spacing", gcyc_q[i] - gcyc_q[i-1], 3);
        end
        request(0, 1'b0, '0);
        repeat (5) step();
        chk("sim_final_rd", bus.rsp_rdata, 32'hA3);

        // req1 and req3 continuously requesting alternate.
        do_reset();
        grants_q.delete(); gcyc_q.delete();
        rereq = 4'b1010;
        request(1, 1'b1, 32'h1);
        request(3, 1'b1, 32'h3);
        repeat (24) step();
        rereq = '0;
        repeat (10) step();
        chk("alt_ngrants_ge6", grants_q.size() >= 6, 1'b1);
        for (int k = 0; k < 6 && k < grants_q.size(); k++)
            chk("alt_order", grants_q[k], (k % 2 == 0) ? 1 : 3);

        // Reset during CAPTURE of a read; the dropped read never responds.
        request(1, 1'b0, '0);
        step();
        request(0, 1'b1, 32'h5A5A_5A5A);
        request(2, 1'b1, 32'h0F0F_0F0F);
        step();
        do_reset();
        grants_q.delete();
        for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
        step();
        chk("rst_first_grant", bus.req_ready, 4'b0001);
        repeat (8) step();
        chk("rst_ngrants", grants_q.size(), 2);
        if (grants_q.size() == 2) chk("rst_second_grant", grants_q[1], 2);
        chk("rst_no_rsp1", rsp_cnt[1], 0);
        chk("rst_rsp0", rsp_cnt[0], 1);

        // Write data changed after grant does not reach DMAC_CFG.
        request(2, 1'b1, 32'h1111_1111);
        step();
        bus.req_wdata[2*W +: W] = 32'h2222_2222;
        chk("commit_wdata", bus.cfg_wdata, 32'h1111_1111);
        repeat (2) step();
        request(2, 1'b0, 32'h2222_2222);
        repeat (4) step();
        chk("commit_rd", bus.rsp_rdata, 32'h1111_1111);

        // Idle: nothing strobes, rdata holds.
        nidle = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (|{bus.cfg_wren, bus.cfg_rden, bus.req_ready, bus.rsp_valid}) nidle++;
        end
        chk("idle_quiet", nidle, 0);
        chk("idle_rdata_hold", bus.rsp_rdata, 32'h1111_1111);

        // Random traffic against the model.
        rand_mode = 1'b1;
        repeat (400) step();
        rand_mode = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < N; i++) if (rq_st[i] == 1) rq_st[i] = 0;
        repeat (8) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmac_cfg_arbiter.md
Name: dmac_cfg_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single-port DMAC_CFG register (wren/rden/wdata/rdata) between NUM_REQ requesters.
Each requester issues a read or write with a valid/ready handshake and receives a one-cycle response pulse, carrying read data for reads.
Sits between the DMAC's software and engine-side config clients and the DMAC_CFG register instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, config data width; matches DMAC_CFG

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-high
req_valid_i  input  NUM_REQ  per-requester request valid
req_write_i  input  NUM_REQ  1 = write, 0 = read
req_wdata_i  input  NUM_REQ*DATA_W  write data; requester i uses bits [i*DATA_W +: DATA_W]
req_ready_o  output  NUM_REQ  one-hot pulse: request accepted
rsp_valid_o  output  NUM_REQ  one-hot pulse: transaction complete
rsp_rdata_o  output  DATA_W  read data, qualified by rsp_valid_o of a read
cfg_wren_o  output  1  to DMAC_CFG wren_i
cfg_rden_o  output  1  to DMAC_CFG rden_i
cfg_wdata_o  output  DATA_W  to DMAC_CFG wdata_i
cfg_rdata_i  input  DATA_W  from DMAC_CFG rdata_o; valid the cycle after rden

Behaviour:
- Reset (rst_n = 1, asynchronous):
  - all outputs 0, state IDLE, RR pointer 0, grant register 0.
  - any in-flight transaction is dropped; no response is ever issued for it.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE, cycle T:
  - if any req_valid_i is set, choose a winner by round-robin: the first set bit searching upward from the pointer, wrapping modulo NUM_REQ.
  - latch the winner index, its req_write_i and its wdata; set pointer = winner+1 mod NUM_REQ.
  - go to ISSUE.
  - if no request, stay in IDLE with all strobes 0.
- ISSUE, cycle T+1:
  - req_ready_o[g] = 1.
  - cfg_wren_o = 1 for a write, cfg_rden_o = 1 for a read; exactly one strobe, for exactly one cycle.
  - cfg_wdata_o = latched wdata; cfg_wdata_o is 0 whenever cfg_wren_o = 0.
  - next state: RESP for a write, CAPTURE for a read.
- CAPTURE (reads only), cycle T+2:
  - cfg_rdata_i is valid this cycle; register it into rsp_rdata_o.
  - go to RESP.
- RESP:
  - rsp_valid_o[g] = 1 for one cycle: T+2 for writes, T+3 for reads.
  - then return to IDLE. Arbitration resumes the following cycle, so there are no back-to-back grants.
- Request commitment:
  - the transaction is committed at grant (cycle T).
  - changes to req_valid_i, req_write_i or req_wdata_i after T do not affect the in-flight transaction.
- Requester obligations:
  - hold req_valid_i until req_ready_o.
  - a requester must not re-request until its rsp_valid_o.
- rsp_rdata_o:
  - holds the last read value and is unchanged by writes.
  - 0 after reset.
- Simultaneous requests: only the RR winner is served; all others stay pending with req_ready_o = 0.
- A requester whose valid drops while waiting (never granted) is simply skipped.
- Throughput: write occupies 3 cycles (IDLE→ISSUE→RESP), read occupies 4.

Decomposition:
- Package dmac_cfg_pkg:
  - state enum (IDLE, ISSUE, CAPTURE, RESP).
  - DATA_W default constant.
  - localparam for the index width, $clog2(NUM_REQ).
- One sub-module, dmac_rr_arbiter:
  - combinational round-robin pick.
  - inputs: request vector, pointer. Outputs: one-hot grant, grant index, any-grant.
  - the pointer register stays in the top level.

Test Plan:
1. req0 writes 0x0123_4567 (req seen at T) -> cfg_wren_o = 1 and cfg_wdata_o = 0x0123_4567 at T+1, req_ready_o = 0001 at T+1, rsp_valid_o = 0001 at T+2. Then req0 reads -> cfg_rden_o at T'+1, rsp_valid_o = 0001 with rsp_rdata_o = 0x0123_4567 at T'+3.
2. After reset, all 4 requesters write distinct values (0xA0..0xA3) simultaneously and hold -> grants in order 0,1,2,3, each 3 cycles apart. Final read returns 0xA3.
3. req1 and req3 continuously valid -> grant sequence 1,3,1,3…; req0 and req2 never receive ready.
4. Assert reset during CAPTURE of a read -> all outputs 0 immediately, no rsp_valid_o. After release, the first pending request, req0, is granted first (pointer back to 0).
5. req2 changes req_wdata_i from 0x1111_1111 to 0x2222_2222 the cycle after grant -> cfg_wdata_o = 0x1111_1111.
6. No requests for 20 cycles -> cfg_wren_o, cfg_rden_o, req_ready_o and rsp_valid_o all stay 0; rsp_rdata_o holds its last value.
